// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;

  typedef logic [3:0] key_code_t;

  typedef struct packed {
    logic      none;
    key_code_t code;
  } cand_t;

  // NONE always carries a zero code so candidates compare with plain equality.
  localparam cand_t CAND_NONE = '{none: 1'b1, code: 4'h0};

  function automatic logic [COLS-1:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-scan debouncer: tracks how many consecutive scans produced the same candidate.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  eval_i,
  input  cand_t cand_i,
  output logic  accept_key_o,
  output logic  accept_release_o
);

  cand_t      prev_q, prev_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    prev_d           = prev_q;
    cnt_d            = cnt_q;
    accept_key_o     = 1'b0;
    accept_release_o = 1'b0;
    if (eval_i) begin
      prev_d = cand_i;
      if (cand_i == prev_q) begin
        cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
      // Exact match so a stable run is accepted once, not every scan.
      if (cnt_d == 4'(DEBOUNCE_SCANS)) begin
        accept_key_o     = ~cand_i.none;
        accept_release_o = cand_i.none;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= CAND_NONE;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column drive, row snapshot, single-key classification.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 4096,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output key_code_t  key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned   DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0]        div_q, div_d;
  logic [1:0]           col_q, col_d;
  logic [ROWS*COLS-1:0] snap_q, snap_d;
  key_code_t            key_code_q, key_code_d;
  logic                 key_valid_q, key_held_q, key_held_d;

  logic                 sample, scan_end;
  logic [4:0]           ones;
  key_code_t            hit;
  cand_t                cand;
  logic                 accept_key, accept_release;

  assign sample   = (div_q == DIV_LAST);
  assign scan_end = sample && (col_q == 2'd3);

  always_comb begin
    div_d  = sample ? '0 : div_q + 1'b1;
    col_d  = sample ? col_q + 2'd1 : col_q;
    snap_d = snap_q;
    if (sample) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        snap_d[{2'(r), col_q}] = ~row_in[r];
      end
    end
  end

  // Classify the snapshot including the incoming column-3 sample, so the
  // decision registers on that edge and key_valid is a flop output in EVAL.
  always_comb begin
    ones = '0;
    hit  = '0;
    for (int unsigned k = 0; k < ROWS*COLS; k++) begin
      if (snap_d[k]) begin
        ones = ones + 5'd1;
        hit  = 4'(k);
      end
    end
    cand = CAND_NONE;
    if (ones == 5'd1) begin
      cand.none = 1'b0;
      cand.code = hit;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk_i           (clk),
    .rst_i           (rst),
    .eval_i          (scan_end),
    .cand_i          (cand),
    .accept_key_o    (accept_key),
    .accept_release_o(accept_release)
  );

  always_comb begin
    key_code_d = key_code_q;
    key_held_d = key_held_q;
    if (accept_key) begin
      key_code_d = cand.code;
      key_held_d = 1'b1;
    end else if (accept_release) begin
      key_held_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      col_q       <= '0;
      snap_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      col_q       <= col_d;
      snap_q      <= snap_d;
      key_code_q  <= key_code_d;
      key_valid_q <= accept_key;
      key_held_q  <= key_held_d;
    end
  end

  assign col_out   = col_drive(col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scan table plus randomized scans vs a per-scan model.
module tb_keypad_scanner;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in = 4'hF;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scan-level reference: one candidate per 16-key mask, debounced over scans.
  int         m_prev = -1;
  int         m_cnt  = 0;
  logic [3:0] exp_code  = 4'h0;
  logic       exp_valid = 1'b0;
  logic       exp_held  = 1'b0;

  typedef struct {
    logic [15:0] mask;
    logic        v;
    logic [3:0]  code;
    logic        held;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] mask, input logic v, input logic [3:0] code, input logic held);
    vec_t e;
    e.mask = mask; e.v = v; e.code = code; e.held = held;
    tbl.push_back(e);
  endtask

  task automatic model_update(input logic [15:0] mask);
    int cand;
    cand = -1;
    if ($countones(mask) == 1) begin
      for (int k = 0; k < 16; k++) if (mask[k]) cand = k;
    end
    m_cnt  = (cand == m_prev) ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 1;
    m_prev = cand;
    exp_valid = 1'b0;
    if (m_cnt == DB) begin
      if (cand >= 0) begin
        exp_valid = 1'b1;
        exp_code  = 4'(cand);
        exp_held  = 1'b1;
      end else begin
        exp_held = 1'b0;
      end
    end
  endtask

  task automatic check_model();
    chk("model_valid", key_valid, exp_valid);
    chk("model_code", key_code, exp_code);
    chk("model_held", key_held, exp_held);
  endtask

  // Key (r,c) pressed pulls row r low while column c is driven.
  task automatic drive_rows(input logic [15:0] mask);
    int c;
    logic [3:0] rv;
    c = 0;
    for (int i = 0; i < 4; i++) if (!col_out[i]) c = i;
    for (int r = 0; r < 4; r++) rv[r] = ~mask[r*4 + c];
    row_in = rv;
  endtask

  // Entered and left at the negedge of a scan's first cycle.
  task automatic do_scan(input logic [15:0] mask);
    logic [3:0] ec;
    for (int i = 0; i < 16; i++) begin
      drive_rows(mask);
      ec = 4'hF;
      ec[i/4] = 1'b0;
      chk("col_out", col_out, ec);
      if (i == 0) check_model();
      else chk("valid_idle", key_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    model_update(mask);
  endtask

  function automatic logic [15:0] rand_mask();
    int kind;
    int a;
    int b;
    kind = $urandom_range(0, 3);
    a = $urandom_range(0, 15);
    b = (a + $urandom_range(1, 15)) % 16;
    if (kind == 0) return 16'h0;
    if (kind == 3) return (16'h1 << a) | (16'h1 << b);
    return 16'h1 << a;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_col", col_out, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    rst = 1'b0;

    // Key (2,1) = bit 9, held then released, then bounce, chord, and key change.
    for (int i = 0; i < 2; i++)  push(16'h0200, 1'b0, 4'h0, 1'b0);
    push(16'h0200, 1'b1, 4'h9, 1'b1);
    for (int i = 0; i < 20; i++) push(16'h0200, 1'b0, 4'h9, 1'b1);
    for (int i = 0; i < 2; i++)  push(16'h0000, 1'b0, 4'h9, 1'b1);
    push(16'h0000, 1'b0, 4'h9, 1'b0);
    for (int i = 0; i < 12; i++) push((i % 2 == 0) ? 16'h0001 : 16'h0000, 1'b0, 4'h9, 1'b0);
    for (int i = 0; i < 6; i++)  push(16'h4020, 1'b0, 4'h9, 1'b0);
    for (int i = 0; i < 2; i++)  push(16'h0020, 1'b0, 4'h9, 1'b0);
    push(16'h0020, 1'b1, 4'h5, 1'b1);
    for (int i = 0; i < 2; i++)  push(16'h0008, 1'b0, 4'h5, 1'b1);
    push(16'h0008, 1'b1, 4'h3, 1'b1);
    for (int i = 0; i < 2; i++)  push(16'h1000, 1'b0, 4'h3, 1'b1);
    push(16'h1000, 1'b1, 4'hC, 1'b1);
    for (int i = 0; i < 2; i++)  push(16'h0000, 1'b0, 4'hC, 1'b1);
    push(16'h0000, 1'b0, 4'hC, 1'b0);

    foreach (tbl[i]) begin
      do_scan(tbl[i].mask);
      chk("tbl_valid", key_valid, tbl[i].v);
      chk("tbl_code", key_code, tbl[i].code);
      chk("tbl_held", key_held, tbl[i].held);
    end

    // Accept (3,0), then reset partway through the next scan.
    for (int i = 0; i < 3; i++) do_scan(16'h1000);
    for (int i = 0; i < 6; i++) begin
      drive_rows(16'h1000);
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_col", col_out, 4'b1110);
    chk("arst_code", key_code, 4'h0);
    chk("arst_valid", key_valid, 1'b0);
    chk("arst_held", key_held, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_prev = -1; m_cnt = 0; exp_code = 4'h0; exp_valid = 1'b0; exp_held = 1'b0;

    // Same key after reset must still need three fresh scans.
    for (int i = 0; i < 3; i++) do_scan(16'h1000);

    for (int run = 0; run < 25; run++) begin
      logic [15:0] m;
      int len;
      m   = rand_mask();
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) do_scan(m);
    end
    do_scan(16'h0000);
    check_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the multiplexed seven-segment display driver. It drives the columns of a 4x4 matrix keypad one at a time (active-low, one-cold, same scheme as the digit selects) and reads the row lines. It debounces across whole scans and reports a single debounced keypress as a 4-bit code with a one-cycle valid pulse. Player/menu logic consumes `key_code`/`key_valid`; the value is typically also echoed to the display driver.

## Interface
- `SCAN_DIV`, default 4096: clock cycles each column is driven (dwell); legal ≥ 2.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-scan results required to accept a change; legal 1..15.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `row_in`  in  4  keypad rows, active-low (pulled up); bit r = row r.
- `col_out`  out  4  column drive, active-low one-cold; bit c = column c.
- `key_code`  out  4  last accepted key, `{row[1:0], col[1:0]}`.
- `key_valid`  out  1  one-cycle pulse when a new key is accepted.
- `key_held`  out  1  high while the accepted key is still debounced-pressed.

## Operation
- Divider counts 0..SCAN_DIV-1 per column. Column index counts 0..3 and wraps 3→0, advancing when the divider wraps.
- `col_out` = `~(4'b0001 << col)` at all times (never all-high, never two low).
- Sample point: divider == SCAN_DIV-1. The bit for key (r, col) = `~row_in[r]` is stored into a 16-bit snapshot. Rows are not sampled at other times.
- Scan end: the sample for column 3. The next cycle (EVAL) classifies the snapshot:
  - 0 bits set: candidate = NONE.
  - Exactly 1 bit set: candidate = that key code.
  - ≥2 bits set (ghosting/chord): candidate = NONE.
- Debounce, also in EVAL:
  - If candidate == previous candidate, the stable count increments, saturating at 15.
  - Otherwise the stable count is set to 1. The previous candidate is set to the current candidate in both cases.
- Acceptance, checked in the same EVAL cycle using the updated count. It applies only when stable count == DEBOUNCE_SCANS exactly, so it fires once per stable run:
  - Candidate is a key: `key_code` ← candidate; `key_valid` pulses; `key_held` ← 1. This also applies when the candidate is a different key while one is held.
  - Candidate is NONE: `key_held` ← 0; `key_code` keeps its value.
- A key held indefinitely produces no further pulses (no auto-repeat).

## Timing
- Reset values: `col_out`=4'b1110, `key_code`=4'h0, `key_valid`=0, `key_held`=0. Internal reset values: divider 0, column 0, snapshot 0, previous candidate NONE, stable count 0.
- Reset mid-scan discards the partial snapshot and all debounce history. Acceptance then needs DEBOUNCE_SCANS new complete scans.
- Full scan period = 4·SCAN_DIV cycles. Column changes take effect the cycle after divider = SCAN_DIV-1, so rows get SCAN_DIV-1 cycles to settle before each sample.
- `key_valid` is registered. It is high for exactly the one cycle after the column-3 sample of the accepting scan, and `key_code` is valid in that same cycle.
- `key_held` changes in the same cycle as the `key_valid` rise, or at the release acceptance.
- Minimum press-to-pulse latency: DEBOUNCE_SCANS full scans + 1 cycle, measured from the start of the first scan that sees the key.
- The EVAL cycle overlaps the first dwell cycle of column 0. Scanning never stalls.

## Structure
- `keypad_pkg`: ROWS=4, COLS=4, `key_code_t` (logic [3:0]), candidate type with explicit NONE flag (`{logic none; key_code_t code;}`), `col_drive(idx)` function.
- One sub-module, `keypad_debounce`: takes the candidate plus an eval strobe; holds the previous candidate and stable count; outputs accept-key and accept-release strobes. Scanner top holds the divider, column counter, snapshot and classification.

## Test plan
Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3 (scan = 16 cycles).

- Reset: assert `rst` asynchronously mid-dwell → outputs immediately 4'b1110/0/0/0. Release → `col_out` sequence 1110,1101,1011,0111 with 4 cycles each, repeating.
- Single press: pull `row_in[2]` low whenever `col_out`=4'b1101, from scan start → exactly one `key_valid` pulse 49 cycles later with `key_code`=4'h9, `key_held`=1. Holding 10 more scans gives no further pulses.
- Release: stop pulling → `key_held` falls after 3 empty scans; `key_code` stays 4'h9; no pulse.
- Bounce: key (0,0) present on alternate scans for 12 scans → no `key_valid`; `key_held` stays 0.
- Chord: keys (1,1) and (3,2) held together for 6 scans → no pulse. Release (3,2) → after 3 scans one pulse with `key_code`=4'h5.
- Key change while held: (0,3) accepted (code 4'h3), then switch directly to (3,0) → one pulse with `key_code`=4'hC; `key_held` remains 1 throughout.
